dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-ported data memory between the core's load/store path (port 0) and a loader/debug master (port 1). It sits between the requesters and the data memory, whose read is combinational and whose write commits on the clock edge. It grants one access per cycle with round-robin fairness, supports locked bursts with a starvation cap, and returns read data registered one cycle after acceptance.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grants to one locked port while the other port is requesting (range 1–15).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `p0_req` in 1: port 0 access request, held until granted.
- `p0_we` in 1: port 0 write enable (1 = write, 0 = read).
- `p0_lock` in 1: port 0 burst lock; keeps the grant while asserted.
- `p0_addr` in 32: port 0 byte address.
- `p0_wdata` in 32: port 0 write data.
- `p0_gnt` out 1: port 0 request accepted this cycle.
- `p0_rvalid` out 1: port 0 read data valid.
- `p0_rdata` out 32: port 0 read data.
- `p1_*`: identical set for port 1.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: combinational memory read data.

## Operation
- **Registered state:**
  - `last`: port granted most recently. Reset value 1, so port 0 wins the first conflict.
  - `owner_valid`, `owner`: lock holder.
  - `burst_cnt[3:0]`: consecutive locked grants.
  - `rsel`, `rpend`: read return steering.
- **Arbitration** is combinational from the requests and registered state. At most one `pN_gnt` is high per cycle.
  - **Locked owner:** if `owner_valid` and the owner is requesting, grant the owner. Exception: if the other port is requesting and `burst_cnt == MAX_BURST`, grant the other port, clear `owner_valid` and clear `burst_cnt`.
  - **Single requester:** otherwise, a single requester is granted.
  - **Conflict:** both requesting grants the port `!= last`.
  - **No requests:** all grants 0 and all memory strobes 0.
- **Memory drive on grant:** `mem_read = !we`, `mem_write = we`, and address/wdata are muxed from the granted port. Ungranted cycles drive address and wdata 0.
- **Lock update** on an accepted beat:
  - if `pN_lock` is 1, set `owner = N` and `owner_valid = 1`;
  - if `pN_lock` is 0, clear `owner_valid`;
  - `burst_cnt` increments when the other port was also requesting, saturating at `MAX_BURST`; otherwise it holds;
  - a grant to a new owner loads `burst_cnt = 1` if contended, else 0.
- **Idle owner:** if the owner drops `req`, `owner_valid` stays set, but the other port may be granted. Granting it clears `owner_valid`.
- **`last`** updates to the granted port on every grant.
- **Read return:** on a read grant, capture `mem_rdata` into `pN_rdata` of the granted port at the clock edge, and pulse that port's `pN_rvalid` for 1 cycle.
  - Writes produce no `rvalid`.
  - `pN_rdata` holds its value until the next read to that port.
- **Request rules:** a requester must hold `req`, `we`, `addr` and `wdata` stable until `gnt`. Deasserting `req` before `gnt` withdraws the request with no side effects.

## Timing
- **Grant latency:** 0 cycles; `gnt` is asserted in the same cycle as `req` when that port wins.
- **Read latency:** data is valid on `pN_rvalid` exactly 1 cycle after the `gnt` cycle.
  - Back-to-back reads to the same port give `rvalid` on consecutive cycles.
- **Write commit:** the write takes effect at the clock edge ending the `gnt` cycle.
  - A read to the same address granted in the next cycle returns the new data.
- **Throughput:** 1 access per cycle total.
  - Contended without lock: strict alternation, 0,1,0,1…
  - Contended with lock: owner gets `MAX_BURST` beats, then 1 beat to the other port.
- **Reset values:** all `gnt`, `rvalid` and `mem_*` strobes are 0; `rdata` 0; `last` 1; `owner_valid` 0; `burst_cnt` 0.
- **Reset mid-operation:** an `rvalid` pending from a read granted in the cycle where `rst` falls is discarded; `rvalid` stays 0 until the first post-reset grant.
- **Simultaneous events:**
  - If the owner drops `lock` on a beat exactly at the `MAX_BURST` cap, that beat is still granted to the owner and ownership then clears.
  - Two requests in the first cycle after reset: port 0 wins.

## Test plan
- Reset, then both ports read, `p0_addr=0x10`, `p1_addr=0x20`, memory preloaded `mem[i]=i` → cycle 0 `p0_gnt=1`, `mem_addr=0x10`; cycle 1 `p0_rvalid=1`, `p0_rdata=4`, `p1_gnt=1`; cycle 2 `p1_rvalid=1`, `p1_rdata=8`.
- Port 1 writes `0xDEAD` to `0x40`, then port 0 reads `0x40` in the next cycle → `p0_rdata=0xDEAD` one cycle after `p0_gnt`; no `p1_rvalid` for the write.
- `MAX_BURST=4`, port 0 holds `lock`/`req` for 8 reads while port 1 requests continuously → grant sequence 0,0,0,0,1,0,0,0,0,1; `burst_cnt` never exceeds 4.
- Port 0 reads with `p0_addr=0x13` → `mem_addr=0x10`, `p0_rdata=4`.
- Assert `rst=0` in the cycle after a port 0 read grant → `p0_rvalid` stays 0, all outputs at reset values, `last=1`; after release, first contended request is granted to port 0.
- Port 1 requests then drops `req` before `gnt` while port 0 has a locked burst → no `mem_*` activity for port 1 and no `p1_rvalid`.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// dmem_arbiter: round-robin arbiter sharing one single-ported data memory between
// two masters, with locked bursts capped at MAX_BURST beats under contention.
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic        p0_lock,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  logic        last, owner_valid, owner, rpend, rsel;
  logic [3:0]  burst_cnt;
  logic        owner_valid_nxt, owner_nxt;
  logic [3:0]  burst_cnt_nxt;
  logic        gnt_any, gsel, capped, contended, sel_we, rd_gnt;
  logic [1:0]  req, lock;
  logic [31:0] sel_addr, sel_wdata;

  assign req  = {p1_req, p0_req};
  assign lock = {p1_lock, p0_lock};

  always_comb begin
    gnt_any = 1'b0;
    gsel    = 1'b0;
    capped  = 1'b0;
    if (owner_valid && req[owner]) begin
      gnt_any = 1'b1;
      // A locked owner that has used up its burst yields one beat; an owner
      // dropping lock on that beat keeps it and releases afterwards.
      if (req[~owner] && lock[owner] && burst_cnt == BURST_CAP) begin
        gsel   = ~owner;
        capped = 1'b1;
      end else begin
        gsel = owner;
      end
    end else if (req == 2'b11) begin
      gnt_any = 1'b1;
      gsel    = ~last;
    end else if (req != 2'b00) begin
      gnt_any = 1'b1;
      gsel    = req[1];
    end
  end

  assign contended = req[~gsel];
  assign sel_we    = gsel ? p1_we    : p0_we;
  assign sel_addr  = gsel ? p1_addr  : p0_addr;
  assign sel_wdata = gsel ? p1_wdata : p0_wdata;
  assign rd_gnt    = gnt_any & ~sel_we;

  assign p0_gnt    = gnt_any & ~gsel;
  assign p1_gnt    = gnt_any & gsel;
  assign mem_read  = rd_gnt;
  assign mem_write = gnt_any & sel_we;
  assign mem_addr  = gnt_any ? (sel_addr & ~32'h3) : 32'h0;
  assign mem_wdata = gnt_any ? sel_wdata : 32'h0;

  always_comb begin
    owner_valid_nxt = owner_valid;
    owner_nxt       = owner;
    burst_cnt_nxt   = burst_cnt;
    if (gnt_any) begin
      if (capped) begin
        owner_valid_nxt = 1'b0;
        burst_cnt_nxt   = 4'd0;
      end else if (lock[gsel]) begin
        owner_valid_nxt = 1'b1;
        owner_nxt       = gsel;
        if (owner_valid && owner == gsel) begin
          if (contended && burst_cnt < BURST_CAP) burst_cnt_nxt = burst_cnt + 4'd1;
        end else begin
          burst_cnt_nxt = contended ? 4'd1 : 4'd0;
        end
      end else begin
        owner_valid_nxt = 1'b0;
        burst_cnt_nxt   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last        <= 1'b1;
      owner_valid <= 1'b0;
      owner       <= 1'b0;
      burst_cnt   <= 4'd0;
      rpend       <= 1'b0;
      rsel        <= 1'b0;
      p0_rdata    <= 32'h0;
      p1_rdata    <= 32'h0;
    end else begin
      owner_valid <= owner_valid_nxt;
      owner       <= owner_nxt;
      burst_cnt   <= burst_cnt_nxt;
      rpend       <= rd_gnt;
      rsel        <= gsel;
      if (gnt_any) last <= gsel;
      if (rd_gnt && !gsel) p0_rdata <= mem_rdata;
      if (rd_gnt && gsel)  p1_rdata <= mem_rdata;
    end
  end

  assign p0_rvalid = rpend & ~rsel;
  assign p1_rvalid = rpend & rsel;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// each cycle against a transaction-level model with its own memory image.
module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory the DUT actually drives (combinational read, clocked write)
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  // Reference model state
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rd [2];
  bit          exp_rv [2];
  int          last_g, holder, streak, dut_g;
  int          n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_g = 1; holder = -1; streak = 0;
    exp_rd[0] = 0; exp_rd[1] = 0; exp_rv[0] = 0; exp_rv[1] = 0;
  endtask

  // One cycle: inputs already set after a negedge; check, advance model, wait next negedge.
  task automatic step(output int g);
    bit r[2], lk[2], w[2];
    logic [31:0] a[2], d[2];
    logic [31:0] e_addr, e_wdata;
    bit e_rd, e_wr, capped;
    #1;
    r[0] = p0_req; lk[0] = p0_lock; w[0] = p0_we; a[0] = p0_addr; d[0] = p0_wdata;
    r[1] = p1_req; lk[1] = p1_lock; w[1] = p1_we; a[1] = p1_addr; d[1] = p1_wdata;
    g = -1; capped = 0;
    if (holder >= 0 && r[holder]) begin
      if (r[1-holder] && lk[holder] && streak == MAXB) begin g = 1 - holder; capped = 1; end
      else g = holder;
    end else if (r[0] && r[1]) g = 1 - last_g;
    else if (r[0]) g = 0;
    else if (r[1]) g = 1;
    e_addr = 0; e_wdata = 0; e_rd = 0; e_wr = 0;
    if (g >= 0) begin
      e_addr = {a[g][31:2], 2'b00}; e_wdata = d[g]; e_rd = !w[g]; e_wr = w[g];
    end
    dut_g = p1_gnt ? 1 : (p0_gnt ? 0 : -1);
    check("p0_gnt", p0_gnt, g == 0);
    check("p1_gnt", p1_gnt, g == 1);
    check("mem_read", mem_read, e_rd);
    check("mem_write", mem_write, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("p0_rvalid", p0_rvalid, exp_rv[0]);
    check("p1_rvalid", p1_rvalid, exp_rv[1]);
    check("p0_rdata", p0_rdata, exp_rd[0]);
    check("p1_rdata", p1_rdata, exp_rd[1]);
    exp_rv[0] = 0; exp_rv[1] = 0;
    if (g >= 0 && rst) begin
      if (e_rd) begin exp_rv[g] = 1; exp_rd[g] = ref_mem[a[g][9:2]]; end
      else ref_mem[a[g][9:2]] = d[g];
      last_g = g;
      if (capped) begin holder = -1; streak = 0; end
      else if (lk[g]) begin
        if (holder == g) begin
          if (r[1-g] && streak < MAXB) streak++;
        end else begin
          holder = g; streak = r[1-g] ? 1 : 0;
        end
      end else begin holder = -1; streak = 0; end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    int g;
    idle_inputs();
    rst = 0;
    model_reset();
    @(negedge clk);
    step(g);
    rst = 1;
  endtask

  int g, p0_done, p1_gnts;
  int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit pend [2];

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = i; ref_mem[i] = i; end
    do_reset();

    // Contended reads after reset: port 0 first
    p0_req = 1; p0_addr = 32'h10; p1_req = 1; p1_addr = 32'h20;
    step(g);
    check("first_conflict_port0", dut_g, 0);
    p0_req = 0;
    step(g);
    p1_req = 0;
    check("tp1_p0_rdata", p0_rdata, 32'd4);
    step(g);
    check("tp1_p1_rdata", p1_rdata, 32'd8);

    // Write then read-after-write on the other port
    p1_req = 1; p1_we = 1; p1_addr = 32'h40; p1_wdata = 32'hDEAD;
    step(g);
    p1_req = 0; p1_we = 0;
    p0_req = 1; p0_addr = 32'h40;
    step(g);
    p0_req = 0;
    check("raw_p1_rvalid", p1_rvalid, 1'b0);
    step(g);
    check("raw_p0_rdata", p0_rdata, 32'hDEAD);

    // Locked burst against continuous port 1 traffic
    do_reset();
    p0_lock = 1; p0_addr = 32'h0; p1_addr = 32'h80; p1_req = 1;
    p0_done = 0;
    for (int i = 0; i < 10; i++) begin
      p0_req = (p0_done < 8);
      p0_addr = 32'(p0_done * 4);
      step(g);
      check($sformatf("burst_seq%0d", i), dut_g, exp_seq[i]);
      if (g == 0) p0_done++;
    end
    p0_lock = 0; p0_req = 0; p1_req = 0;

    // Unaligned address
    p0_req = 1; p0_addr = 32'h13;
    step(g);
    p0_req = 0;
    check("unaligned_rdata", p0_rdata, 32'd4);

    // Reset asserted the cycle after a read grant
    p0_req = 1; p0_addr = 32'h18;
    step(g);
    p0_req = 0; rst = 0;
    #1;
    check("rst_p0_rvalid", p0_rvalid, 1'b0);
    check("rst_p0_rdata", p0_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    step(g);
    rst = 1;
    p0_req = 1; p1_req = 1; p0_addr = 32'h20; p1_addr = 32'h24;
    step(g);
    check("post_rst_conflict", dut_g, 0);
    idle_inputs();
    step(g);

    // Port 1 withdraws during a port 0 locked burst
    do_reset();
    p1_gnts = 0;
    p0_req = 1; p0_lock = 1; p0_addr = 32'h30;
    step(g);
    p1_req = 1; p1_we = 1; p1_addr = 32'h50; p1_wdata = 32'h1234;
    step(g); if (dut_g == 1) p1_gnts++;
    p1_req = 0;
    for (int i = 0; i < 3; i++) begin step(g); if (dut_g == 1) p1_gnts++; end
    check("withdraw_p1_gnts", p1_gnts, 0);
    check("withdraw_mem", mem[8'h14], 32'h14);
    idle_inputs();
    step(g);

    // Random traffic
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && $urandom_range(99) < 4) pend[p] = 0;
        else if (!pend[p] && $urandom_range(99) < 55) begin
          pend[p] = 1;
          if (p == 0) begin
            p0_we = $urandom_range(1); p0_addr = $urandom(); p0_wdata = $urandom();
            p0_lock = ($urandom_range(99) < 40);
          end else begin
            p1_we = $urandom_range(1); p1_addr = $urandom(); p1_wdata = $urandom();
            p1_lock = ($urandom_range(99) < 40);
          end
        end
      end
      p0_req = pend[0]; p1_req = pend[1];
      step(g);
      if (g >= 0) pend[g] = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
